// File: rtl/pll_cntr_reconfig_ctrl_if.sv
// ---------------------------------------------------------------------------
// pll_cntr_reconfig_ctrl_if
//   Request/response bundle between the reconfig register block (master) and
//   the PLL counter reconfiguration sequencer (slave).
//
//   req_valid  master->slave  request valid
//   req_idx    master->slave  target counter index
//   req_div    master->slave  requested divide ratio (0 means off)
//   req_phase  master->slave  requested initial_value
//   req_off    master->slave  force the counter off
//   req_ready  slave->master  sequencer idle, request can be taken
//   done       slave->master  one-cycle completion pulse
//   err        slave->master  qualifies done: request rejected
//   busy       slave->master  sequence in progress
// ---------------------------------------------------------------------------
interface pll_cntr_reconfig_ctrl_if #(
   parameter int DIV_W = 9,
   parameter int PH_W  = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_idx;
   logic [DIV_W-1:0] req_div;
   logic [PH_W-1:0]  req_phase;
   logic             req_off;
   logic             done;
   logic             err;
   logic             busy;

   // Requester side: drives the request, watches the handshake/status.
   modport master (
      output req_valid, req_idx, req_div, req_phase, req_off,
      input  req_ready, done, err, busy
   );

   // Sequencer side.
   modport slave (
      input  req_valid, req_idx, req_div, req_phase, req_off,
      output req_ready, done, err, busy
   );
endinterface

// File: rtl/pll_cntr_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// pll_cntr_reconfig_ctrl
//   Runtime reconfiguration sequencer for the PLL output scale-down counters.
//   One request at a time: the requested divide ratio / phase / off flag is
//   turned into mode/high/low/initial_value settings, the target counter is
//   held in reset while its settings are swapped, then a settle time elapses
//   before done is pulsed.
//
//   clk         controller clock
//   reset_n     asynchronous active-low reset
//   bus         request/response interface (slave modport)
//   cntr_reset  per-counter reset, active high
//   cntr_mode   per-counter mode, 2 bits each: 0 off, 1 bypass, 2 even, 3 odd
//   cntr_high   per-counter high count, 32 bits each
//   cntr_low    per-counter low count, 32 bits each
//   cntr_init   per-counter initial_value, 32 bits each
// ---------------------------------------------------------------------------
module pll_cntr_reconfig_ctrl #(
   parameter int NUM_CNTR      = 10,
   parameter int DIV_W         = 9,
   parameter int PH_W          = 8,
   parameter int RST_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   pll_cntr_reconfig_ctrl_if.slave  bus,
   output logic [NUM_CNTR-1:0]      cntr_reset,
   output logic [2*NUM_CNTR-1:0]    cntr_mode,
   output logic [32*NUM_CNTR-1:0]   cntr_high,
   output logic [32*NUM_CNTR-1:0]   cntr_low,
   output logic [32*NUM_CNTR-1:0]   cntr_init
);

   localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   localparam logic [1:0] MODE_OFF  = 2'd0;
   localparam logic [1:0] MODE_BYP  = 2'd1;
   localparam logic [1:0] MODE_EVEN = 2'd2;
   localparam logic [1:0] MODE_ODD  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST,
      ST_LOAD,
      ST_SETTLE,
      ST_DONE,
      ST_REJ
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]  idx_q;
   logic [1:0]  mode_q;
   logic [31:0] high_q, low_q, init_q;

   logic [1:0]  mode_arr [NUM_CNTR];
   logic [31:0] high_arr [NUM_CNTR];
   logic [31:0] low_arr  [NUM_CNTR];
   logic [31:0] init_arr [NUM_CNTR];

   logic        req_bad;
   logic [31:0] div_ext;
   logic [1:0]  enc_mode;
   logic [31:0] enc_high, enc_low, enc_init;

   // Translate the raw request into counter settings. Off and bypass both
   // park high/low/init at 1; odd ratios put the extra cycle in the high half.
   always_comb begin
      div_ext  = 32'(bus.req_div);
      enc_mode = MODE_OFF;
      enc_high = 32'd1;
      enc_low  = 32'd1;
      enc_init = 32'd1;
      if (!bus.req_off && div_ext != 32'd0) begin
         if (div_ext == 32'd1) begin
            enc_mode = MODE_BYP;
         end else if (!div_ext[0]) begin
            enc_mode = MODE_EVEN;
            enc_high = div_ext >> 1;
            enc_low  = div_ext >> 1;
            enc_init = 32'(bus.req_phase);
         end else begin
            enc_mode = MODE_ODD;
            enc_high = (div_ext >> 1) + 32'd1;
            enc_low  = div_ext >> 1;
            enc_init = 32'(bus.req_phase);
         end
      end
   end

   // A request is refused when it names a counter that does not exist, or
   // asks for an active divide with a zero initial_value.
   always_comb begin
      req_bad = ({28'd0, bus.req_idx} >= 32'(NUM_CNTR)) ||
                (!bus.req_off && div_ext != 32'd0 && bus.req_phase == '0);
   end

   // State and cycle counter registers; reset drops any sequence in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. The same counter times both the reset hold and the
   // settle window; it is cleared on entry to each.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_d = req_bad ? ST_REJ : ST_RST;
               cnt_d   = '0;
            end
         end
         ST_RST: begin
            if (cnt_q == RST_LAST) state_d = ST_LOAD;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = (SETTLE_CYCLES == 0) ? ST_DONE : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = ST_DONE;
            else                      cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_DONE, ST_REJ: state_d = ST_IDLE;
         default:         state_d = ST_IDLE;
      endcase
   end

   // Moore outputs. The target counter's reset covers both RST and LOAD so
   // its settings change while it is still held.
   always_comb begin
      bus.req_ready = (state_q == ST_IDLE);
      bus.busy      = (state_q != ST_IDLE);
      bus.done      = (state_q == ST_DONE) || (state_q == ST_REJ);
      bus.err       = (state_q == ST_REJ);
      cntr_reset    = '0;
      for (int i = 0; i < NUM_CNTR; i++) begin
         if ((state_q == ST_RST || state_q == ST_LOAD) && idx_q == 4'(i))
            cntr_reset[i] = 1'b1;
      end
   end

   // Snapshot of the request at accept; the requester may change its inputs
   // as soon as the handshake completes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q  <= '0;
         mode_q <= MODE_OFF;
         high_q <= 32'd1;
         low_q  <= 32'd1;
         init_q <= 32'd1;
      end else if (state_q == ST_IDLE && bus.req_valid) begin
         idx_q  <= bus.req_idx;
         mode_q <= enc_mode;
         high_q <= enc_high;
         low_q  <= enc_low;
         init_q <= enc_init;
      end
   end

   // Counter settings bank: only the targeted counter is written, and only
   // on the last cycle it is held in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CNTR; i++) begin
            mode_arr[i] <= MODE_OFF;
            high_arr[i] <= 32'd1;
            low_arr[i]  <= 32'd1;
            init_arr[i] <= 32'd1;
         end
      end else if (state_q == ST_LOAD) begin
         for (int i = 0; i < NUM_CNTR; i++) begin
            if (idx_q == 4'(i)) begin
               mode_arr[i] <= mode_q;
               high_arr[i] <= high_q;
               low_arr[i]  <= low_q;
               init_arr[i] <= init_q;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CNTR; g++) begin : g_out
      assign cntr_mode[2*g +: 2]  = mode_arr[g];
      assign cntr_high[32*g +: 32] = high_arr[g];
      assign cntr_low[32*g +: 32]  = low_arr[g];
      assign cntr_init[32*g +: 32] = init_arr[g];
   end

endmodule

// File: tb/tb_pll_cntr_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_cntr_reconfig_ctrl
//   Self-checking bench for pll_cntr_reconfig_ctrl. A per-counter settings
//   model is updated from the encoding rules whenever a request is issued,
//   and the DUT's timing and outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_pll_cntr_reconfig_ctrl;

   localparam int NUM    = 10;
   localparam int DIV_W  = 9;
   localparam int PH_W   = 8;
   localparam int RST_C  = 4;
   localparam int SET_C  = 16;
   localparam int LAT    = RST_C + 1 + SET_C + 1;
   localparam int BUDGET = 60;
   localparam int DIVMAX = (1 << DIV_W) - 1;

   typedef logic [2*NUM-1:0]  mvec_t;
   typedef logic [32*NUM-1:0] wvec_t;

   logic  clk = 1'b0;
   logic  reset_n = 1'b0;
   logic  [NUM-1:0] cntr_reset;
   mvec_t cntr_mode;
   wvec_t cntr_high, cntr_low, cntr_init;

   int n_checks = 0;
   int n_errors = 0;

   pll_cntr_reconfig_ctrl_if #(.DIV_W(DIV_W), .PH_W(PH_W)) bus ();

   pll_cntr_reconfig_ctrl #(
      .NUM_CNTR(NUM), .DIV_W(DIV_W), .PH_W(PH_W),
      .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .cntr_reset(cntr_reset), .cntr_mode(cntr_mode),
      .cntr_high(cntr_high), .cntr_low(cntr_low), .cntr_init(cntr_init)
   );

   always #5 clk = ~clk;

   // Reference model of the counter settings bank.
   int unsigned m_mode [NUM];
   int unsigned m_high [NUM];
   int unsigned m_low  [NUM];
   int unsigned m_init [NUM];

   // Observations gathered while a request runs.
   int    obs_done_cyc, obs_rst_cnt, obs_rst_first;
   logic  obs_err, obs_stray, obs_busy_bad, obs_ready_bad;
   logic  obs_ready_after, obs_busy_after;
   mvec_t pre_mode, mid_mode, fin_mode;
   wvec_t pre_high, mid_high, fin_high, fin_low, fin_init;

   mvec_t old_mode, new_mode;
   wvec_t old_high, old_low, old_init, new_high, new_low, new_init;

   task automatic model_reset();
      for (int i = 0; i < NUM; i++) begin
         m_mode[i] = 0; m_high[i] = 1; m_low[i] = 1; m_init[i] = 1;
      end
   endtask

   // Spec rules in plain arithmetic: returns whether the request is refused.
   task automatic model_apply(input int idx, input int div, input int phase,
                              input bit off, output bit bad);
      bad = (idx >= NUM) || (!off && div != 0 && phase == 0);
      if (!bad) begin
         if (off || div == 0) begin
            m_mode[idx] = 0; m_high[idx] = 1; m_low[idx] = 1; m_init[idx] = 1;
         end else if (div == 1) begin
            m_mode[idx] = 1; m_high[idx] = 1; m_low[idx] = 1; m_init[idx] = 1;
         end else if (div % 2 == 0) begin
            m_mode[idx] = 2; m_high[idx] = div / 2; m_low[idx] = div / 2; m_init[idx] = phase;
         end else begin
            m_mode[idx] = 3; m_high[idx] = (div + 1) / 2; m_low[idx] = (div - 1) / 2;
            m_init[idx] = phase;
         end
      end
   endtask

   task automatic model_vectors(output mvec_t m, output wvec_t h, output wvec_t l,
                                output wvec_t n);
      int unsigned t;
      for (int i = 0; i < NUM; i++) begin
         t = m_mode[i];
         m[2*i +: 2]  = t[1:0];
         h[32*i +: 32] = m_high[i];
         l[32*i +: 32] = m_low[i];
         n[32*i +: 32] = m_init[i];
      end
   endtask

   // Issues one request at a negedge where the DUT is idle and records what
   // happens until the cycle after done. With hold_junk the requester keeps
   // req_valid high with changing garbage for the whole sequence.
   task automatic run_req(input int idx, input int div, input int phase,
                          input bit off, input bit hold_junk);
      logic [NUM-1:0] mask;
      mask = '0;
      if (idx < NUM) mask[idx] = 1'b1;
      obs_done_cyc = 0; obs_rst_cnt = 0; obs_rst_first = 0;
      obs_err = 1'b0; obs_stray = 1'b0; obs_busy_bad = 1'b0; obs_ready_bad = 1'b0;
      obs_ready_after = 1'b0; obs_busy_after = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_idx   = 4'(idx);
      bus.req_div   = DIV_W'(div);
      bus.req_phase = PH_W'(phase);
      bus.req_off   = off;
      @(posedge clk);
      for (int n = 1; n <= BUDGET && obs_done_cyc == 0; n++) begin
         @(negedge clk);
         if (hold_junk) begin
            bus.req_idx   = 4'($urandom_range(0, 15));
            bus.req_div   = DIV_W'($urandom);
            bus.req_phase = PH_W'($urandom);
            bus.req_off   = 1'($urandom);
         end else begin
            bus.req_valid = 1'b0;
         end
         if ((cntr_reset & ~mask) != '0) obs_stray = 1'b1;
         if ((cntr_reset & mask) != '0) begin
            obs_rst_cnt++;
            if (obs_rst_first == 0) obs_rst_first = n;
         end
         if (bus.busy !== 1'b1) obs_busy_bad = 1'b1;
         if (bus.req_ready !== 1'b0) obs_ready_bad = 1'b1;
         if (n == 1 || n == RST_C + 1) begin
            pre_mode = cntr_mode; pre_high = cntr_high;
         end
         if (n == RST_C + 2) begin
            mid_mode = cntr_mode; mid_high = cntr_high;
         end
         if (bus.done === 1'b1) begin
            obs_done_cyc = n;
            obs_err = bus.err;
            if (n < RST_C + 2) begin
               mid_mode = cntr_mode; mid_high = cntr_high;
            end
         end
      end
      if (obs_done_cyc != 0) begin
         @(negedge clk);
         obs_ready_after = bus.req_ready;
         obs_busy_after  = bus.busy;
         fin_mode = cntr_mode; fin_high = cntr_high;
         fin_low  = cntr_low;  fin_init = cntr_init;
      end
   endtask

   task automatic test_reset();
      model_reset();
      model_vectors(new_mode, new_high, new_low, new_init);
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.req_ready, bus.done, bus.err, bus.busy} !== 4'b1000) begin
         n_errors++;
         $display("[TB] FAIL reset_status: got ready/done/err/busy=%b expected 1000",
                  {bus.req_ready, bus.done, bus.err, bus.busy});
      end
      n_checks++;
      if (cntr_reset !== '0) begin
         n_errors++; $display("[TB] FAIL reset_cntr_reset: got %b expected 0", cntr_reset);
      end
      n_checks++;
      if ({cntr_mode, cntr_high, cntr_low, cntr_init} !== {new_mode, new_high, new_low, new_init}) begin
         n_errors++;
         $display("[TB] FAIL reset_settings: got mode=%h high=%h expected mode=%h high=%h",
                  cntr_mode, cntr_high, new_mode, new_high);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_even();
      bit bad;
      model_vectors(old_mode, old_high, old_low, old_init);
      run_req(0, 4, 1, 1'b0, 1'b0);
      model_apply(0, 4, 1, 1'b0, bad);
      model_vectors(new_mode, new_high, new_low, new_init);
      n_checks++;
      if (obs_done_cyc !== LAT || obs_err !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL even_done: got cycle %0d err %b expected cycle %0d err 0",
                  obs_done_cyc, obs_err, LAT);
      end
      n_checks++;
      if (obs_rst_cnt !== RST_C + 1 || obs_rst_first !== 1 || obs_stray !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL even_reset_pulse: got %0d cycles from %0d stray %b expected %0d from 1 stray 0",
                  obs_rst_cnt, obs_rst_first, obs_stray, RST_C + 1);
      end
      n_checks++;
      if (pre_high !== old_high || pre_mode !== old_mode) begin
         n_errors++;
         $display("[TB] FAIL even_load_timing: settings changed before end of load, got high=%h expected %h",
                  pre_high, old_high);
      end
      n_checks++;
      if (mid_high !== new_high || mid_mode !== new_mode) begin
         n_errors++;
         $display("[TB] FAIL even_after_load: got high=%h mode=%h expected high=%h mode=%h",
                  mid_high, mid_mode, new_high, new_mode);
      end
      n_checks++;
      if ({fin_mode[1:0], fin_high[31:0], fin_low[31:0], fin_init[31:0]} !== {2'd2, 32'd2, 32'd2, 32'd1}) begin
         n_errors++;
         $display("[TB] FAIL even_cntr0: got mode %0d high %0d low %0d init %0d expected 2 2 2 1",
                  fin_mode[1:0], fin_high[31:0], fin_low[31:0], fin_init[31:0]);
      end
      n_checks++;
      if (obs_busy_bad !== 1'b0 || obs_ready_bad !== 1'b0 || obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL even_handshake: busy_gap %b ready_early %b ready_after %b busy_after %b expected 0 0 1 0",
                  obs_busy_bad, obs_ready_bad, obs_ready_after, obs_busy_after);
      end
   endtask

   task automatic test_odd();
      bit bad;
      run_req(3, 7, 5, 1'b0, 1'b0);
      model_apply(3, 7, 5, 1'b0, bad);
      model_vectors(new_mode, new_high, new_low, new_init);
      n_checks++;
      if ({fin_mode[7:6], fin_high[127:96], fin_low[127:96], fin_init[127:96]} !== {2'd3, 32'd4, 32'd3, 32'd5}) begin
         n_errors++;
         $display("[TB] FAIL odd_cntr3: got mode %0d high %0d low %0d init %0d expected 3 4 3 5",
                  fin_mode[7:6], fin_high[127:96], fin_low[127:96], fin_init[127:96]);
      end
      n_checks++;
      if ({fin_mode, fin_high, fin_low, fin_init} !== {new_mode, new_high, new_low, new_init}) begin
         n_errors++;
         $display("[TB] FAIL odd_bank: got mode=%h high=%h expected mode=%h high=%h",
                  fin_mode, fin_high, new_mode, new_high);
      end
   endtask

   task automatic test_bypass_off();
      bit bad;
      run_req(1, 1, 3, 1'b0, 1'b0);
      model_apply(1, 1, 3, 1'b0, bad);
      n_checks++;
      if ({fin_mode[3:2], fin_high[63:32], fin_low[63:32], fin_init[63:32]} !== {2'd1, 32'd1, 32'd1, 32'd1}) begin
         n_errors++;
         $display("[TB] FAIL bypass_cntr1: got mode %0d high %0d low %0d init %0d expected 1 1 1 1",
                  fin_mode[3:2], fin_high[63:32], fin_low[63:32], fin_init[63:32]);
      end
      run_req(1, 9, 0, 1'b1, 1'b0);
      model_apply(1, 9, 0, 1'b1, bad);
      model_vectors(new_mode, new_high, new_low, new_init);
      n_checks++;
      if (obs_err !== 1'b0 || fin_mode[3:2] !== 2'd0) begin
         n_errors++;
         $display("[TB] FAIL off_cntr1: got err %b mode %0d expected err 0 mode 0", obs_err, fin_mode[3:2]);
      end
      n_checks++;
      if (fin_mode[1:0] !== 2'd2 || fin_high[31:0] !== 32'd2 || fin_low[31:0] !== 32'd2) begin
         n_errors++;
         $display("[TB] FAIL off_cntr0_untouched: got mode %0d high %0d low %0d expected 2 2 2",
                  fin_mode[1:0], fin_high[31:0], fin_low[31:0]);
      end
   endtask

   task automatic test_reject();
      bit bad;
      model_vectors(old_mode, old_high, old_low, old_init);
      run_req(12, 5, 3, 1'b0, 1'b0);
      model_apply(12, 5, 3, 1'b0, bad);
      n_checks++;
      if (obs_done_cyc !== 1 || obs_err !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL reject_idx_done: got cycle %0d err %b expected cycle 1 err 1", obs_done_cyc, obs_err);
      end
      n_checks++;
      if (obs_rst_cnt !== 0 || obs_stray !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reject_idx_reset: got %0d target cycles stray %b expected 0 0", obs_rst_cnt, obs_stray);
      end
      n_checks++;
      if ({fin_mode, fin_high, fin_low, fin_init} !== {old_mode, old_high, old_low, old_init}) begin
         n_errors++;
         $display("[TB] FAIL reject_idx_settings: got mode=%h high=%h expected mode=%h high=%h",
                  fin_mode, fin_high, old_mode, old_high);
      end
      run_req(4, 6, 0, 1'b0, 1'b0);
      model_apply(4, 6, 0, 1'b0, bad);
      n_checks++;
      if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_rst_cnt !== 0 || fin_mode !== old_mode) begin
         n_errors++;
         $display("[TB] FAIL reject_phase0: got cycle %0d err %b rst %0d mode=%h expected 1 1 0 mode=%h",
                  obs_done_cyc, obs_err, obs_rst_cnt, fin_mode, old_mode);
      end
   endtask

   task automatic test_back_to_back();
      bit bad;
      run_req(5, 10, 3, 1'b0, 1'b1);
      model_apply(5, 10, 3, 1'b0, bad);
      model_vectors(new_mode, new_high, new_low, new_init);
      n_checks++;
      if (obs_done_cyc !== LAT || obs_ready_after !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL b2b_first: got done cycle %0d ready_after %b expected %0d 1",
                  obs_done_cyc, obs_ready_after, LAT);
      end
      n_checks++;
      if ({fin_mode, fin_high, fin_low, fin_init} !== {new_mode, new_high, new_low, new_init}) begin
         n_errors++;
         $display("[TB] FAIL b2b_junk_ignored: got mode=%h high=%h expected mode=%h high=%h",
                  fin_mode, fin_high, new_mode, new_high);
      end
      run_req(5, 11, 2, 1'b0, 1'b0);
      model_apply(5, 11, 2, 1'b0, bad);
      model_vectors(new_mode, new_high, new_low, new_init);
      n_checks++;
      if (obs_done_cyc !== LAT || obs_rst_first !== 1 || obs_busy_bad !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL b2b_second_timing: got done %0d rst_first %0d busy_gap %b expected %0d 1 0",
                  obs_done_cyc, obs_rst_first, obs_busy_bad, LAT);
      end
      n_checks++;
      if ({fin_mode, fin_high, fin_low, fin_init} !== {new_mode, new_high, new_low, new_init}) begin
         n_errors++;
         $display("[TB] FAIL b2b_second_settings: got mode=%h high=%h expected mode=%h high=%h",
                  fin_mode, fin_high, new_mode, new_high);
      end
   endtask

   task automatic test_random();
      int idx, div, phase, sel;
      bit off, bad;
      for (int k = 0; k < 30; k++) begin
         idx = $urandom_range(0, 11);
         sel = $urandom_range(0, 5);
         div = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? DIVMAX : $urandom_range(2, DIVMAX);
         phase = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
         off = ($urandom_range(0, 5) == 0);
         model_vectors(old_mode, old_high, old_low, old_init);
         run_req(idx, div, phase, off, 1'b0);
         model_apply(idx, div, phase, off, bad);
         model_vectors(new_mode, new_high, new_low, new_init);
         n_checks++;
         if (obs_done_cyc !== (bad ? 1 : LAT) || obs_err !== bad) begin
            n_errors++;
            $display("[TB] FAIL rand%0d_done: idx %0d div %0d ph %0d off %b got cycle %0d err %b expected %0d %b",
                     k, idx, div, phase, off, obs_done_cyc, obs_err, bad ? 1 : LAT, bad);
         end
         n_checks++;
         if (obs_rst_cnt !== (bad ? 0 : RST_C + 1) || obs_stray !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL rand%0d_reset: got %0d cycles stray %b expected %0d stray 0",
                     k, obs_rst_cnt, obs_stray, bad ? 0 : RST_C + 1);
         end
         n_checks++;
         if (pre_mode !== old_mode || pre_high !== old_high || mid_mode !== new_mode || mid_high !== new_high) begin
            n_errors++;
            $display("[TB] FAIL rand%0d_update_timing: pre mode=%h mid mode=%h expected pre %h mid %h",
                     k, pre_mode, mid_mode, old_mode, new_mode);
         end
         n_checks++;
         if ({fin_mode, fin_high, fin_low, fin_init} !== {new_mode, new_high, new_low, new_init}) begin
            n_errors++;
            $display("[TB] FAIL rand%0d_settings: got high=%h low=%h expected high=%h low=%h",
                     k, fin_high, fin_low, new_high, new_low);
         end
         n_checks++;
         if (obs_busy_bad !== 1'b0 || obs_ready_bad !== 1'b0 || obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL rand%0d_handshake: busy_gap %b ready_early %b ready_after %b busy_after %b expected 0 0 1 0",
                     k, obs_busy_bad, obs_ready_bad, obs_ready_after, obs_busy_after);
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.req_valid = 1'b1;
      bus.req_idx   = 4'd2;
      bus.req_div   = DIV_W'(6);
      bus.req_phase = PH_W'(2);
      bus.req_off   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (9) @(negedge clk);
      n_checks++;
      if (cntr_mode[5:4] !== 2'd2 || bus.busy !== 1'b1 || cntr_reset !== '0) begin
         n_errors++;
         $display("[TB] FAIL midsettle_state: got mode2 %0d busy %b reset %b expected 2 1 0",
                  cntr_mode[5:4], bus.busy, cntr_reset);
      end
      reset_n = 1'b0;
      model_reset();
      model_vectors(new_mode, new_high, new_low, new_init);
      #1;
      n_checks++;
      if ({bus.req_ready, bus.done, bus.err, bus.busy} !== 4'b1000 || cntr_reset !== '0) begin
         n_errors++;
         $display("[TB] FAIL midreset_status: got ready/done/err/busy=%b reset=%b expected 1000 0",
                  {bus.req_ready, bus.done, bus.err, bus.busy}, cntr_reset);
      end
      n_checks++;
      if ({cntr_mode, cntr_high, cntr_low, cntr_init} !== {new_mode, new_high, new_low, new_init}) begin
         n_errors++;
         $display("[TB] FAIL midreset_settings: got mode=%h high=%h expected mode=%h high=%h",
                  cntr_mode, cntr_high, new_mode, new_high);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL midreset_release: got ready %b busy %b expected 1 0", bus.req_ready, bus.busy);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_idx   = '0;
      bus.req_div   = '0;
      bus.req_phase = '0;
      bus.req_off   = 1'b0;
      $display("[TB] start");
      test_reset();
      test_even();
      test_odd();
      test_bypass_off();
      test_reject();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
